umi_crossbar_arbiter: RTL and testbench

//  - Per-output-port arbiter for the UMI crossbar: picks one of N input requesters for one output.
//  - Holds the grant stable across back-pressure until the UMI valid/ready handshake completes.
//  - One instance per crossbar output; the grant one-hot drives the output mux select and input ready.

---
 rtl/umi_arb_pkg.sv | 13 +
 rtl/umi_crossbar_arbiter_if.sv | 23 ++
 rtl/umi_arb_rr_pick.sv | 30 +++
 rtl/umi_crossbar_arbiter.sv | 140 ++++++++++++++
 tb/tb_umi_crossbar_arbiter.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/umi_arb_pkg.sv
// Shared types for the UMI crossbar output arbiter.
// Holds the arbiter state encoding and the mode[1] selector values.
package umi_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam logic ARB_MODE_PRIO = 1'b0;
  localparam logic ARB_MODE_RR   = 1'b1;

endpackage

// File: rtl/umi_crossbar_arbiter_if.sv
// Request/grant bundle between one crossbar output and its arbiter.
// The master side drives the requests; the slave side is the arbiter.
interface umi_crossbar_arbiter_if #(
  parameter int N = 4
);
  logic [1:0]   mode;
  logic [N-1:0] mask;
  logic [N-1:0] request;
  logic         out_ready;
  logic [N-1:0] grant;
  logic         out_valid;
  logic         busy;

  modport master (
    output mode, mask, request, out_ready,
    input  grant, out_valid, busy
  );

  modport slave (
    input  mode, mask, request, out_ready,
    output grant, out_valid, busy
  );
endinterface

// File: rtl/umi_arb_rr_pick.sv
// Rotating-priority picker: first set bit of req searching upward from ptr, wrapping N-1 -> 0.
// With ptr tied to zero it degenerates to a lowest-index-wins priority encoder.
module umi_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW:0]   pos;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap so N need not be a power of two.
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && req[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/umi_crossbar_arbiter.sv
// Per-output arbiter for the UMI crossbar; grant is held until the valid/ready handshake completes.
// Optional starvation watchdog is built when UMI_ARB_WATCHDOG_EN is defined.
module umi_crossbar_arbiter
  import umi_arb_pkg::*;
#(
  parameter int N            = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  umi_crossbar_arbiter_if.slave  bus
);

  localparam int PW = $clog2(N);

  arb_state_t    state_reg, state_next;
  logic [N-1:0]  hold_reg, hold_next;
  logic          rr_mode_reg, rr_mode_next;
  logic [PW-1:0] ptr_reg, ptr_next;

  logic [N-1:0]  eff;
  logic [N-1:0]  pick_prio, pick_rr, urgent_eff, pick_urg;
  logic [N-1:0]  grant_c;
  logic [PW-1:0] grant_idx;
  logic          out_valid_c, transfer;
  logic          unused_mode0;

  assign eff          = bus.request & ~bus.mask;
  assign unused_mode0 = bus.mode[0];

  umi_arb_rr_pick #(.N(N)) u_pick_prio (.req(eff), .ptr('0),     .gnt(pick_prio));
  umi_arb_rr_pick #(.N(N)) u_pick_rr   (.req(eff), .ptr(ptr_reg), .gnt(pick_rr));

`ifdef UMI_ARB_WATCHDOG_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_reg [N];
  logic [N-1:0]  urgent;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_wdog
      // Waiting is counted against the grant actually presented this cycle.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (!bus.request[gi] || bus.mask[gi] || (transfer && grant_c[gi])) begin
          cnt_reg[gi] <= '0;
        end else if (!grant_c[gi] && cnt_reg[gi] != CW'(STARVE_LIMIT)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
      assign urgent[gi] = (cnt_reg[gi] == CW'(STARVE_LIMIT));
    end
  endgenerate

  assign urgent_eff = urgent & eff;
  umi_arb_rr_pick #(.N(N)) u_pick_urg (.req(urgent_eff), .ptr('0), .gnt(pick_urg));
`else
  logic [31:0] unused_limit;
  assign unused_limit = 32'(STARVE_LIMIT);
  assign urgent_eff   = '0;
  assign pick_urg     = '0;
`endif

  always_comb begin
    grant_c = '0;
    if (reset) begin
      grant_c = '0;
    end else if (state_reg == ARB_LOCKED) begin
      // A dropped request under lock blanks the grant instead of forwarding a stale select.
      grant_c = hold_reg & bus.request;
    end else if (|urgent_eff) begin
      grant_c = pick_urg;
    end else if (bus.mode[1] == ARB_MODE_RR) begin
      grant_c = pick_rr;
    end else begin
      grant_c = pick_prio;
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_c[i]) grant_idx = PW'(i);
    end
  end

  assign out_valid_c = |(grant_c & bus.request);
  assign transfer    = out_valid_c & bus.out_ready;

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    rr_mode_next = rr_mode_reg;
    ptr_next     = ptr_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (transfer) begin
          if (bus.mode[1] == ARB_MODE_RR) begin
            ptr_next = (grant_idx == PW'(N-1)) ? '0 : grant_idx + 1'b1;
          end
        end else if (out_valid_c) begin
          state_next   = ARB_LOCKED;
          hold_next    = grant_c;
          rr_mode_next = bus.mode[1];
        end
      end
      ARB_LOCKED: begin
        if (!out_valid_c) begin
          state_next = ARB_IDLE;
        end else if (transfer) begin
          state_next = ARB_IDLE;
          if (rr_mode_reg == ARB_MODE_RR) begin
            ptr_next = (grant_idx == PW'(N-1)) ? '0 : grant_idx + 1'b1;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ARB_IDLE;
      hold_reg    <= '0;
      rr_mode_reg <= ARB_MODE_PRIO;
      ptr_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      rr_mode_reg <= rr_mode_next;
      ptr_reg     <= ptr_next;
    end
  end

  assign bus.grant     = grant_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = (state_reg == ARB_LOCKED);

endmodule

// File: tb/tb_umi_crossbar_arbiter.sv
// Scoreboard bench for umi_crossbar_arbiter; expected grants are queued at drive time
// and popped on each observed transfer. Watchdog sequence runs when UMI_ARB_WATCHDOG_EN is defined.
module tb_umi_crossbar_arbiter;

  localparam int N = 4;
`ifdef UMI_ARB_WATCHDOG_EN
  localparam int LIMIT = 3;
`else
  localparam int LIMIT = 15;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  umi_crossbar_arbiter_if #(.N(N)) bus ();

  umi_crossbar_arbiter #(.N(N), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [N-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every completed handshake must match the oldest queued grant.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        $display("xfer grant=%b expected=%b", bus.grant, e);
        check_val("sb_xfer", 32'(bus.grant), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, queue the expected transfer, check combinational outputs, advance.
  task automatic step(input logic [1:0] m, input logic [3:0] mk, input logic [3:0] rq,
                      input logic rdy, input logic [3:0] eg, input logic ev, input logic eb,
                      input string tag);
    bus.mode      = m;
    bus.mask      = mk;
    bus.request   = rq;
    bus.out_ready = rdy;
    if (ev && rdy) exp_q.push_back(eg);
    #2;
    check_val({tag, "_grant"}, 32'(bus.grant), 32'(eg));
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'(ev));
    check_val({tag, "_busy"},  32'(bus.busy), 32'(eb));
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.mode      = 2'b00;
    bus.mask      = '0;
    bus.request   = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_grant", 32'(bus.grant), 32'd0);
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_busy",  32'(bus.busy), 32'd0);
    reset = 1'b0;
    cyc();

`ifdef UMI_ARB_WATCHDOG_EN
    // Requester 3 starves behind 0 for LIMIT cycles, wins once, then starts over.
    for (int c = 0; c < 8; c++) begin
      step(2'b00, 4'b0000, 4'b1001, 1'b1, (c == 3 || c == 7) ? 4'b1000 : 4'b0001, 1'b1, 1'b0, "wdog");
    end
    step(2'b00, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "wdog_idle");
`else
    // Fixed priority
    step(2'b00, 4'b0000, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b0, "prio_a");
    step(2'b00, 4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, "prio_b");
    step(2'b00, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, "prio_none");

    // Round robin from pointer 0
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 4'b0000, 4'b1111, 1'b1, 4'(1 << (i % 4)), 1'b1, 1'b0, "rr");
    end

    // Back-pressure with pointer at 1: lock on 2, hold against request/mask churn
    step(2'b10, 4'b0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, "bp_arb");
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 4'(i * 5), 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, "bp_hold");
    end
    step(2'b10, 4'b0000, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, "bp_xfer");
    step(2'b10, 4'b0000, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, "bp_ptr3");

    // Mask only affects arbitration in IDLE
    step(2'b10, 4'b0001, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0, "mask_arb");
    step(2'b10, 4'b0000, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1, "mask_lock");
    step(2'b10, 4'b0000, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b1, "mask_xfer");
    step(2'b10, 4'b0000, 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b0, "mask_next");

    // Request drop while locked leaves the pointer at 1
    step(2'b10, 4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, "drop_arb");
    step(2'b10, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, "drop_cyc");
    step(2'b10, 4'b0000, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, "drop_ptr");
`endif

    // Async reset in the middle of a locked cycle
    step(2'b10, 4'b0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, "arst_arb");
    bus.request = 4'b1111;
    #1;
    check_val("arst_pre_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check_val("arst_grant", 32'(bus.grant), 32'd0);
    check_val("arst_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst_busy",  32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(2'b10, 4'b0000, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, "arst_ptr0");
    step(2'b10, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "drain");

    check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
